// File: rtl/minion_lsu_arbiter_if.sv
// minion_lsu_arbiter_if
//   One req/gnt/rvalid data-side bus. It is used for both the master links
//   (LSU, host loader) and the shared slave link toward the address decode.
//
//   req/we/be/addr/wdata : driven by the requester
//   gnt/rvalid/err/rdata : driven by the responder (err is a timeout error)
//
//   modport master : the requesting side
//   modport slave  : the responding side
interface minion_lsu_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            req;
  logic            gnt;
  logic            rvalid;
  logic            err;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/minion_lsu_arbiter.sv
// minion_lsu_arbiter
//   Shares the single data-side slave bus between two masters: m0 (core LSU)
//   and m1 (host/debug loader). At most one transaction is outstanding; its
//   response is routed back to the master that issued it. A watchdog forces
//   an error completion if the slave never returns rvalid.
//
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   m0    : master 0 link (arbiter is the responder)
//   m1    : master 1 link (arbiter is the responder)
//   s     : shared slave link (arbiter is the requester; s.err is not used)
//   busy  : high while a transaction is outstanding
//   owner : master that owns / last owned the outstanding transaction
//   stray : one-cycle pulse when s.rvalid arrives with nothing outstanding
//
//   ARB_MODE : 0 = round-robin, 1 = fixed priority (m0 highest)
//   TIMEOUT  : WAIT cycles before a forced error completion (1..65535)
//   ERR_DATA : rdata returned on a timeout completion
module minion_lsu_arbiter #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   ARB_MODE = 0,
  parameter int unsigned   TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  minion_lsu_arbiter_if.slave  m0,
  minion_lsu_arbiter_if.slave  m1,
  minion_lsu_arbiter_if.master s,
  output logic                 busy,
  output logic                 owner,
  output logic                 stray
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned  WDW       = 16;
  localparam logic [WDW-1:0] WDOG_MAX  = WDW'(TIMEOUT);
  // wdog counts WAIT cycles already completed, so the cycle in which it
  // reads TIMEOUT-1 is the TIMEOUT-th WAIT cycle: the forced completion
  // lands exactly TIMEOUT cycles after the grant.
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rr_q,    rr_d;
  logic [WDW-1:0] wdog_q,  wdog_d;

  logic           any_req;
  logic           sel;
  logic           s_req_c;
  logic           grant;
  logic           busy_c;
  logic           stray_c;
  logic           rsp_valid;
  logic           rsp_err;
  logic [DW-1:0]  rsp_data;

  // ---------------------------------------------------------------------
  // Master selection
  // ---------------------------------------------------------------------
  assign any_req = m0.req | m1.req;

  always_comb begin
    sel = 1'b0;
    case ({m1.req, m0.req})
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11: begin
        if (ARB_MODE == 0) sel = rr_q;
        else               sel = 1'b0;
      end
      default: sel = 1'b0;
    endcase
  end

  // Attributes follow sel unconditionally; they only matter while s.req is up.
  assign s.we    = sel ? m1.we    : m0.we;
  assign s.be    = sel ? m1.be    : m0.be;
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.wdata = sel ? m1.wdata : m0.wdata;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wdog_d    = wdog_q;
    s_req_c   = 1'b0;
    grant     = 1'b0;
    busy_c    = 1'b0;
    stray_c   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;

    case (state_q)
      ST_IDLE: begin
        // rst gating keeps request, grant and stray quiet while reset is
        // held, since the register state alone cannot suppress them.
        s_req_c = any_req & ~rst;
        grant   = s_req_c & s.gnt;
        stray_c = s.rvalid & ~rst;
        if (grant) begin
          owner_d = sel;
          rr_d    = ~sel;
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        busy_c = 1'b1;
        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + WDW'(1);
        if (s.rvalid) begin
          // A real response beats a coinciding timeout.
          rsp_valid = 1'b1;
          rsp_data  = s.rdata;
          state_d   = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          rsp_data  = ERR_DATA;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output routing
  // ---------------------------------------------------------------------
  assign s.req     = s_req_c;

  assign m0.gnt    = grant & ~sel;
  assign m1.gnt    = grant &  sel;

  // rsp_data is zero whenever rsp_valid is low, so the non-owner and the
  // idle owner both see rdata = 0.
  assign m0.rvalid = rsp_valid & ~owner_q;
  assign m1.rvalid = rsp_valid &  owner_q;
  assign m0.err    = rsp_err   & ~owner_q;
  assign m1.err    = rsp_err   &  owner_q;
  assign m0.rdata  = owner_q ? '0 : rsp_data;
  assign m1.rdata  = owner_q ? rsp_data : '0;

  assign busy      = busy_c;
  assign owner     = owner_q;
  assign stray     = stray_c;

endmodule

// File: tb/tb_minion_lsu_arbiter.sv
// tb_minion_lsu_arbiter
//   Two arbiters side by side on identical stimulus: g_dut[0] round-robin,
//   g_dut[1] fixed priority, both with TIMEOUT = 4. A transaction-level
//   model checks every output on every falling edge; directed literal
//   expectations pin the key scenarios.
module tb_minion_lsu_arbiter;

  localparam int TIMEOUT = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_we = 1'b0,  m1_we = 1'b0;
  logic [3:0]  m0_be = 4'hF,  m1_be = 4'hF;
  logic [31:0] m0_addr = '0,  m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        s_gnt = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        o_gnt0 [2], o_gnt1 [2], o_rv0 [2], o_rv1 [2], o_er0 [2], o_er1 [2];
  logic [31:0] o_rd0 [2], o_rd1 [2], o_saddr [2], o_swdata [2];
  logic [3:0]  o_sbe [2];
  logic        o_sreq [2], o_swe [2], o_busy [2], o_owner [2], o_stray [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    minion_lsu_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    minion_lsu_arbiter_if #(.AW(32), .DW(32)) m1_if ();
    minion_lsu_arbiter_if #(.AW(32), .DW(32)) s_if ();

    assign m0_if.req   = m0_req;
    assign m0_if.we    = m0_we;
    assign m0_if.be    = m0_be;
    assign m0_if.addr  = m0_addr;
    assign m0_if.wdata = m0_wdata;
    assign m1_if.req   = m1_req;
    assign m1_if.we    = m1_we;
    assign m1_if.be    = m1_be;
    assign m1_if.addr  = m1_addr;
    assign m1_if.wdata = m1_wdata;
    assign s_if.gnt    = s_gnt;
    assign s_if.rvalid = s_rvalid;
    assign s_if.rdata  = s_rdata;
    assign s_if.err    = 1'b0;

    minion_lsu_arbiter #(
      .AW(32), .DW(32), .ARB_MODE(g), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .busy  (o_busy[g]),
      .owner (o_owner[g]),
      .stray (o_stray[g])
    );

    assign o_gnt0[g]   = m0_if.gnt;
    assign o_gnt1[g]   = m1_if.gnt;
    assign o_rv0[g]    = m0_if.rvalid;
    assign o_rv1[g]    = m1_if.rvalid;
    assign o_er0[g]    = m0_if.err;
    assign o_er1[g]    = m1_if.err;
    assign o_rd0[g]    = m0_if.rdata;
    assign o_rd1[g]    = m1_if.rdata;
    assign o_sreq[g]   = s_if.req;
    assign o_swe[g]    = s_if.we;
    assign o_sbe[g]    = s_if.be;
    assign o_saddr[g]  = s_if.addr;
    assign o_swdata[g] = s_if.wdata;
  end

  task automatic chk1(input string name, input int d, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got=%b expected=%b", name, d, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, d, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level model: per arbiter, whether a transaction is in
  // flight, who owns it, the cycle it was granted, and who wins a tie next.
  // ---------------------------------------------------------------------
  int   cyc = 0;
  bit   m_busy [2];
  bit   m_own  [2];
  bit   m_rr   [2];
  int   m_gcyc [2];

  bit          pick;
  logic        e_gnt0, e_gnt1, e_rv0, e_rv1, e_er0, e_er1;
  logic        e_sreq, e_busy, e_stray, e_owner;
  logic [31:0] e_rd0, e_rd1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
      e_er0 = 1'b0;  e_er1 = 1'b0;  e_rd0 = '0;   e_rd1 = '0;
      e_sreq = 1'b0; e_busy = 1'b0; e_stray = 1'b0; pick = 1'b0;

      if (rst) begin
        m_busy[d] = 1'b0;
        m_own[d]  = 1'b0;
        m_rr[d]   = 1'b0;
      end
      e_owner = m_own[d];

      if (!rst && !m_busy[d]) begin
        if (m0_req && m1_req) pick = (d == 1) ? 1'b0 : m_rr[d];
        else                  pick = m1_req;
        e_sreq  = m0_req | m1_req;
        e_stray = s_rvalid;
        if (e_sreq && s_gnt) begin
          if (pick) e_gnt1 = 1'b1;
          else      e_gnt0 = 1'b1;
          m_busy[d] = 1'b1;
          m_own[d]  = pick;
          m_rr[d]   = !pick;
          m_gcyc[d] = cyc;
        end
      end else if (!rst) begin
        e_busy = 1'b1;
        if (s_rvalid || (cyc - m_gcyc[d] == TIMEOUT)) begin
          if (m_own[d]) begin
            e_rv1 = 1'b1; e_er1 = !s_rvalid; e_rd1 = s_rvalid ? s_rdata : ERR;
          end else begin
            e_rv0 = 1'b1; e_er0 = !s_rvalid; e_rd0 = s_rvalid ? s_rdata : ERR;
          end
          m_busy[d] = 1'b0;
        end
      end

      chk1 ("m0_gnt",    d, o_gnt0[d],  e_gnt0);
      chk1 ("m1_gnt",    d, o_gnt1[d],  e_gnt1);
      chk1 ("m0_rvalid", d, o_rv0[d],   e_rv0);
      chk1 ("m1_rvalid", d, o_rv1[d],   e_rv1);
      chk1 ("m0_err",    d, o_er0[d],   e_er0);
      chk1 ("m1_err",    d, o_er1[d],   e_er1);
      chk32("m0_rdata",  d, o_rd0[d],   e_rd0);
      chk32("m1_rdata",  d, o_rd1[d],   e_rd1);
      chk1 ("s_req",     d, o_sreq[d],  e_sreq);
      chk1 ("busy",      d, o_busy[d],  e_busy);
      chk1 ("owner",     d, o_owner[d], e_owner);
      chk1 ("stray",     d, o_stray[d], e_stray);
      if (e_sreq) begin
        chk32("s_addr",  d, o_saddr[d],  pick ? m1_addr  : m0_addr);
        chk32("s_wdata", d, o_swdata[d], pick ? m1_wdata : m0_wdata);
        chk1 ("s_we",    d, o_swe[d],    pick ? m1_we    : m0_we);
        chk32("s_be",    d, {28'd0, o_sbe[d]}, {28'd0, pick ? m1_be : m0_be});
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------
  // Directed stimulus: inputs change 1 ns after the rising edge; literal
  // expectations are sampled 2 ns later.
  // ---------------------------------------------------------------------
  task automatic set_in(input logic r, input logic a0, input logic a1,
                        input logic g, input logic v, input logic [31:0] rd);
    rst = r; m0_req = a0; m1_req = a1; s_gnt = g; s_rvalid = v; s_rdata = rd;
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  bit rr_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset
    set_in(1, 0, 0, 0, 0, 0); adv();
    set_in(1, 1, 1, 1, 1, 0);
    for (int d = 0; d < 2; d++) begin
      chk1("rst_busy", d, o_busy[d], 1'b0);
      chk1("rst_owner", d, o_owner[d], 1'b0);
      chk1("rst_sreq", d, o_sreq[d], 1'b0);
      chk1("rst_stray", d, o_stray[d], 1'b0);
    end
    adv();
    set_in(0, 0, 0, 0, 0, 0); adv();

    // Contention: both request continuously
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
    m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
    set_in(0, 1, 1, 0, 0, 0);
    chk1("nogrant_m0", 0, o_gnt0[0], 1'b0);
    chk1("nogrant_m1", 0, o_gnt1[0], 1'b0);
    adv();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 1, 1, 0, 0);
      chk1("rr_gnt_m0", 0, o_gnt0[0], !rr_order[k]);
      chk1("rr_gnt_m1", 0, o_gnt1[0], rr_order[k]);
      chk1("fp_gnt_m0", 1, o_gnt0[1], 1'b1);
      chk1("fp_gnt_m1", 1, o_gnt1[1], 1'b0);
      adv();
      set_in(0, 1, 1, 1, 1, 32'h100 + 32'(k));
      chk1 ("rr_rv_m0", 0, o_rv0[0], !rr_order[k]);
      chk1 ("rr_rv_m1", 0, o_rv1[0], rr_order[k]);
      chk1 ("rr_owner", 0, o_owner[0], rr_order[k]);
      chk1 ("fp_rv_m0", 1, o_rv0[1], 1'b1);
      chk32("fp_rdata", 1, o_rd0[1], 32'h100 + 32'(k));
      adv();
    end
    // m0 drops: fixed priority finally serves m1
    set_in(0, 0, 1, 1, 0, 0);
    chk1("fp_m1_late_gnt", 1, o_gnt1[1], 1'b1);
    adv();
    set_in(0, 0, 0, 0, 1, 32'h0000_0BAD);
    chk1("fp_m1_rv", 1, o_rv1[1], 1'b1);
    adv();

    // Single read by m0
    m0_addr = 32'h0010_0010; m0_we = 1'b0;
    set_in(0, 1, 0, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk1 ("rd_gnt", d, o_gnt0[d], 1'b1);
      chk32("rd_addr", d, o_saddr[d], 32'h0010_0010);
    end
    adv();
    set_in(0, 0, 0, 0, 1, 32'h1234_5678);
    for (int d = 0; d < 2; d++) begin
      chk1 ("rd_rv", d, o_rv0[d], 1'b1);
      chk32("rd_data", d, o_rd0[d], 32'h1234_5678);
      chk1 ("rd_err", d, o_er0[d], 1'b0);
      chk1 ("rd_m1_rv", d, o_rv1[d], 1'b0);
      chk32("rd_m1_data", d, o_rd1[d], 32'h0);
    end
    adv();
    set_in(0, 0, 0, 0, 0, 0); adv();

    // Write by m1
    m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'hA5A5_A5A5;
    set_in(0, 0, 1, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk1 ("wr_gnt", d, o_gnt1[d], 1'b1);
      chk1 ("wr_we", d, o_swe[d], 1'b1);
      chk32("wr_be", d, {28'd0, o_sbe[d]}, 32'h3);
      chk32("wr_wdata", d, o_swdata[d], 32'hA5A5_A5A5);
    end
    adv();
    set_in(0, 0, 0, 0, 1, 32'h0);
    for (int d = 0; d < 2; d++) chk1("wr_rv", d, o_rv1[d], 1'b1);
    adv();
    m1_we = 1'b0; m1_be = 4'hF;

    // Timeout, then a late response
    set_in(0, 1, 0, 1, 0, 0); adv();
    for (int w = 1; w < TIMEOUT; w++) begin
      set_in(0, 0, 0, 0, 0, 0);
      chk1("to_busy", 0, o_busy[0], 1'b1);
      chk1("to_early_rv", 0, o_rv0[0], 1'b0);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk1 ("to_rv", d, o_rv0[d], 1'b1);
      chk1 ("to_err", d, o_er0[d], 1'b1);
      chk32("to_data", d, o_rd0[d], 32'hDEAD_BEEF);
    end
    adv();
    set_in(0, 0, 0, 0, 1, 32'h0000_0077);
    for (int d = 0; d < 2; d++) begin
      chk1("late_stray", d, o_stray[d], 1'b1);
      chk1("late_rv0", d, o_rv0[d], 1'b0);
      chk1("late_rv1", d, o_rv1[d], 1'b0);
    end
    adv();

    // Response coinciding with the timeout cycle wins
    set_in(0, 1, 0, 1, 0, 0); adv();
    for (int w = 1; w < TIMEOUT; w++) begin
      set_in(0, 0, 0, 0, 0, 0); adv();
    end
    set_in(0, 0, 0, 0, 1, 32'h5555_AAAA);
    chk1 ("tie_err", 0, o_er0[0], 1'b0);
    chk32("tie_data", 0, o_rd0[0], 32'h5555_AAAA);
    adv();

    // Reset while waiting; the tie-break pointer must be cleared
    set_in(0, 1, 1, 1, 0, 0);
    chk1("pre_rst_rr_gnt_m1", 0, o_gnt1[0], 1'b1);
    adv();
    set_in(0, 1, 1, 1, 0, 0);
    chk1("pre_rst_busy", 0, o_busy[0], 1'b1);
    rst = 1'b1; s_rvalid = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1("mid_rst_busy", d, o_busy[d], 1'b0);
      chk1("mid_rst_sreq", d, o_sreq[d], 1'b0);
      chk1("mid_rst_rv0", d, o_rv0[d], 1'b0);
      chk1("mid_rst_rv1", d, o_rv1[d], 1'b0);
      chk1("mid_rst_gnt0", d, o_gnt0[d], 1'b0);
    end
    adv();
    set_in(1, 1, 1, 1, 1, 0); adv();
    set_in(0, 1, 1, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk1("post_rst_gnt_m0", d, o_gnt0[d], 1'b1);
      chk1("post_rst_gnt_m1", d, o_gnt1[d], 1'b0);
    end
    adv();
    set_in(0, 0, 0, 0, 1, 32'h0000_ABCD);
    for (int d = 0; d < 2; d++) chk1("post_rst_rv", d, o_rv0[d], 1'b1);
    adv();
    set_in(0, 0, 0, 0, 0, 0); adv(); adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
